// File: rtl/counter_seq_ctrl_if.sv
// rtl/counter_seq_ctrl_if.sv - control and status bundle between host and counter_seq_ctrl
interface counter_seq_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             pause;
   logic             auto_reload;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic [1:0]       state;

   // host side drives control, observes count and status
   modport master (
      output start, stop, pause, auto_reload, limit,
      input  q, busy, done, state
   );

   // controller side
   modport slave (
      input  start, stop, pause, auto_reload, limit,
      output q, busy, done, state
   );
endinterface

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - start/stop/pause sequencer for a terminal-count up-counter
module counter_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   counter_seq_ctrl_if.slave   ctl
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r, state_n;
   logic [WIDTH-1:0] q_r, q_n;
   logic [WIDTH-1:0] limit_r, limit_n;
   logic             reload_r, reload_n;
   logic             done_r, done_n;

   // register all state; reset clears everything without a done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         q_r      <= '0;
         limit_r  <= '0;
         reload_r <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_n;
         q_r      <= q_n;
         limit_r  <= limit_n;
         reload_r <= reload_n;
         done_r   <= done_n;
      end
   end

   // next-state: stop beats pause beats terminal beats increment
   always_comb begin
      state_n  = state_r;
      q_n      = q_r;
      limit_n  = limit_r;
      reload_n = reload_r;
      done_n   = 1'b0;
      case (state_r)
         IDLE: begin
            if (ctl.start && !ctl.stop) begin
               limit_n  = ctl.limit;
               reload_n = ctl.auto_reload;
               q_n      = '0;
               state_n  = RUN;
            end
         end
         RUN: begin
            if (ctl.stop) begin
               state_n = IDLE;
            end else if (ctl.pause) begin
               state_n = PAUSE;
            end else if (q_r == limit_r) begin
               // increment is never applied here, so an all-ones limit cannot overflow
               done_n = 1'b1;
               if (reload_r) begin
                  q_n = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               q_n = q_r + ONE;
            end
         end
         PAUSE: begin
            // leaving pause costs one edge with q unchanged
            if (ctl.stop) begin
               state_n = IDLE;
            end else if (!ctl.pause) begin
               state_n = RUN;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // outputs come straight from registers
   always_comb begin
      ctl.q     = q_r;
      ctl.done  = done_r;
      ctl.busy  = (state_r != IDLE);
      ctl.state = state_r;
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - directed and randomized checks of counter_seq_ctrl
module tb_counter_seq_ctrl;

   localparam int WIDTH = 4;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   counter_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

   counter_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctl   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: an activity flag, a paused flag and the count, advanced by the rules
   logic             m_busy;
   logic             m_paused;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] m_lim;
   logic             m_rel;
   logic             m_done;

   task automatic model_reset();
      m_busy = 0; m_paused = 0; m_q = '0; m_lim = '0; m_rel = 0; m_done = 0;
   endtask

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (bus.start && !bus.stop) begin
               m_busy = 1; m_paused = 0; m_q = '0;
               m_lim = bus.limit; m_rel = bus.auto_reload;
            end
         end else if (m_paused) begin
            if (bus.stop) begin
               m_busy = 0; m_paused = 0;
            end else if (!bus.pause) begin
               m_paused = 0;
            end
         end else begin
            if (bus.stop) m_busy = 0;
            else if (bus.pause) m_paused = 1;
            else if (int'(m_q) == int'(m_lim)) begin
               m_done = 1;
               if (m_rel) m_q = '0;
               else m_busy = 0;
            end else begin
               m_q = WIDTH'(int'(m_q) + 1);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic s, input logic p, input logic h,
                         input logic r, input logic [WIDTH-1:0] l);
      bus.start = s; bus.stop = p; bus.pause = h; bus.auto_reload = r; bus.limit = l;
   endtask

   task automatic test_reset();
      set_in(0, 0, 0, 0, '0);
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_hold: q=%0d busy=%0b done=%0b state=%0d, want all 0",
                  bus.q, bus.busy, bus.done, bus.state);
      end
      rst_n = 1;
      set_in(1, 0, 0, 0, 4'd15);
      tick();
      bus.start = 0;
      repeat (7) tick();
      tests_run++;
      if (bus.q !== 4'd7 || bus.state !== 2'd1) begin
         tests_failed++;
         $display("FAIL reset_pre_q: q=%0d state=%0d, want q=7 state=1", bus.q, bus.state);
      end
      #2;
      rst_n = 0;
      model_reset();
      #1;
      tests_run++;
      if (bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_async: q=%0d busy=%0b done=%0b state=%0d, want all 0",
                  bus.q, bus.busy, bus.done, bus.state);
      end
      tick();
      rst_n = 1;
      tick();
      tests_run++;
      if (bus.busy !== 1'b0 || bus.q !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_no_restart: busy=%0b q=%0d, want 0 0", bus.busy, bus.q);
      end
   endtask

   task automatic test_one_shot();
      set_in(1, 0, 0, 0, 4'd5);
      tick();
      set_in(0, 0, 0, 1, 4'd9);
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) tick();
         tests_run++;
         if (bus.q !== WIDTH'(k) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL one_shot_q%0d: q=%0d busy=%0b done=%0b, want q=%0d busy=1 done=0",
                     k, bus.q, bus.busy, bus.done, k);
         end
      end
      tick();
      tests_run++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 4'd5) begin
         tests_failed++;
         $display("FAIL one_shot_term: done=%0b busy=%0b q=%0d, want 1 0 5", bus.done, bus.busy, bus.q);
      end
      tick();
      tests_run++;
      if (bus.done !== 1'b0 || bus.q !== 4'd5 || bus.state !== 2'd0) begin
         tests_failed++;
         $display("FAIL one_shot_after: done=%0b q=%0d state=%0d, want 0 5 0", bus.done, bus.q, bus.state);
      end
   endtask

   task automatic test_auto_reload();
      int pulses;
      int bad;
      pulses = 0;
      bad = 0;
      set_in(1, 0, 0, 1, 4'd3);
      tick();
      set_in(0, 0, 0, 0, 4'd0);
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (bus.done === 1'b1) pulses++;
         if (bus.q !== WIDTH'(k % 4) || bus.busy !== 1'b1 || bus.done !== ((k % 4) == 0)) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL reload_seq: %0d bad cycles, want 0", bad);
      end
      tests_run++;
      if (pulses != 5) begin
         tests_failed++;
         $display("FAIL reload_pulses: got %0d, want 5", pulses);
      end
      bus.stop = 1;
      tick();
      bus.stop = 0;
      tests_run++;
      if (bus.state !== 2'd0 || bus.q !== 4'd1 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reload_stop: state=%0d q=%0d done=%0b, want 0 1 0", bus.state, bus.q, bus.done);
      end
   endtask

   task automatic test_pause();
      int e;
      set_in(1, 0, 0, 0, 4'd15);
      tick();
      bus.start = 0;
      repeat (4) tick();
      e = 4;
      bus.pause = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         e++;
         tests_run++;
         if (bus.state !== 2'd2 || bus.q !== 4'd4) begin
            tests_failed++;
            $display("FAIL pause_hold%0d: state=%0d q=%0d, want 2 4", i, bus.state, bus.q);
         end
      end
      bus.pause = 0;
      tick();
      e++;
      tests_run++;
      if (bus.state !== 2'd1 || bus.q !== 4'd4) begin
         tests_failed++;
         $display("FAIL pause_bubble: state=%0d q=%0d, want 1 4", bus.state, bus.q);
      end
      tick();
      e++;
      tests_run++;
      if (bus.q !== 4'd5) begin
         tests_failed++;
         $display("FAIL pause_resume: q=%0d, want 5", bus.q);
      end
      while (bus.done !== 1'b1 && e < 40) begin
         tick();
         e++;
      end
      tests_run++;
      if (e != 20 || bus.busy !== 1'b0 || bus.q !== 4'd15) begin
         tests_failed++;
         $display("FAIL pause_term: done at edge %0d busy=%0b q=%0d, want 20 0 15", e, bus.busy, bus.q);
      end
      tick();
   endtask

   task automatic test_collisions();
      set_in(1, 0, 0, 0, 4'd2);
      tick();
      bus.start = 0;
      repeat (2) tick();
      bus.stop = 1;
      tick();
      bus.stop = 0;
      tests_run++;
      if (bus.done !== 1'b0 || bus.state !== 2'd0 || bus.q !== 4'd2) begin
         tests_failed++;
         $display("FAIL stop_at_term: done=%0b state=%0d q=%0d, want 0 0 2", bus.done, bus.state, bus.q);
      end
      tick();
      tests_run++;
      if (bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL stop_at_term_late: done=%0b, want 0", bus.done);
      end
      set_in(1, 1, 0, 0, 4'd4);
      tick();
      set_in(0, 0, 0, 0, 4'd0);
      tests_run++;
      if (bus.state !== 2'd0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_stop_idle: state=%0d busy=%0b, want 0 0", bus.state, bus.busy);
      end
      set_in(1, 0, 0, 0, 4'd6);
      tick();
      tick();
      set_in(1, 0, 0, 1, 4'd2);
      tick();
      tick();
      tests_run++;
      if (bus.q !== 4'd3 || bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_while_busy: q=%0d busy=%0b, want 3 1", bus.q, bus.busy);
      end
      bus.start = 0;
      repeat (4) tick();
      tests_run++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 4'd6) begin
         tests_failed++;
         $display("FAIL busy_latch: done=%0b busy=%0b q=%0d, want 1 0 6", bus.done, bus.busy, bus.q);
      end
      tick();
   endtask

   task automatic test_bounds();
      int bad;
      set_in(1, 0, 0, 0, 4'd0);
      tick();
      bus.start = 0;
      tests_run++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.q !== 4'd0) begin
         tests_failed++;
         $display("FAIL lim0_start: busy=%0b done=%0b q=%0d, want 1 0 0", bus.busy, bus.done, bus.q);
      end
      tick();
      tests_run++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 4'd0) begin
         tests_failed++;
         $display("FAIL lim0_oneshot: done=%0b busy=%0b q=%0d, want 1 0 0", bus.done, bus.busy, bus.q);
      end
      set_in(1, 0, 0, 1, 4'd0);
      tick();
      bus.start = 0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done !== 1'b1 || bus.q !== 4'd0 || bus.busy !== 1'b1) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL lim0_reload: %0d bad cycles, want 0", bad);
      end
      bus.stop = 1;
      tick();
      bus.stop = 0;
      set_in(1, 0, 0, 0, 4'd15);
      tick();
      bus.start = 0;
      repeat (15) tick();
      tests_run++;
      if (bus.q !== 4'd15 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL lim15_top: q=%0d done=%0b busy=%0b, want 15 0 1", bus.q, bus.done, bus.busy);
      end
      tick();
      tests_run++;
      if (bus.q !== 4'd15 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL lim15_term: q=%0d done=%0b busy=%0b, want 15 1 0", bus.q, bus.done, bus.busy);
      end
      tick();
   endtask

   task automatic test_random();
      logic [1:0] exp_state;
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                WIDTH'($urandom_range(0, 15)));
         tick();
         exp_state = !m_busy ? 2'd0 : (m_paused ? 2'd2 : 2'd1);
         tests_run++;
         if (bus.q !== m_q || bus.done !== m_done || bus.busy !== m_busy || bus.state !== exp_state) begin
            tests_failed++;
            $display("FAIL random_%0d: q=%0d done=%0b busy=%0b state=%0d, want %0d %0b %0b %0d",
                     i, bus.q, bus.done, bus.busy, bus.state, m_q, m_done, m_busy, exp_state);
         end
      end
      set_in(0, 0, 0, 0, '0);
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst_n = 0;
      set_in(0, 0, 0, 0, '0);
      model_reset();
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_pause();
      test_collisions();
      test_bounds();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencing controller for the team's free-running up-counter datapath. It owns a WIDTH-bit count register and applies start/stop/pause control, a programmable terminal count, and one-shot or auto-reload modes. It reports busy and terminal-count (done) status. It sits between a host/control FSM and any logic that consumes the count value q.

Parameters:
WIDTH, 4, bit width of count value q and of limit.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset; clears all state immediately on assertion.
start  input  1  begin a count sequence; sampled on the rising edge, honoured only in IDLE.
stop  input  1  abort the current sequence; sampled on the rising edge.
pause  input  1  level; freezes counting while high.
auto_reload  input  1  mode select, latched at start: 1 = wrap to 0 at terminal and keep running, 0 = one-shot.
limit  input  WIDTH  terminal count value, latched at start.
q  output  WIDTH  current count (registered).
busy  output  1  high whenever state is not IDLE.
done  output  1  registered one-cycle pulse marking each terminal count.
state  output  2  encoded FSM state: IDLE=0, RUN=1, PAUSE=2.

Behaviour:
- Reset (asynchronous, rst_n=0): q=0, done=0, state=IDLE, busy=0, latched limit_r=0, latched reload_r=0. Release is synchronous to the next edge.
- Outputs: busy is decoded directly from the state register. No combinational path from any input to any output.
- done: defaults to 0 every edge. It is set only by a terminal event as defined below.
- IDLE:
  - q holds its value.
  - On edge N with start=1 and stop=0: limit_r<=limit, reload_r<=auto_reload, q<=0, state<=RUN.
  - start=1 with stop=1 in the same cycle: stop wins; remain IDLE.
- RUN, evaluated in priority order each edge:
  1. stop=1: state<=IDLE, q holds, done stays 0. This applies even in the terminal cycle.
  2. pause=1: state<=PAUSE, q holds.
  3. q==limit_r (terminal event): done<=1.
     - reload_r=1: q<=0, stay RUN.
     - reload_r=0: q holds at limit_r, state<=IDLE.
  4. Otherwise q<=q+1.
- PAUSE:
  - stop=1: go to IDLE, q holds.
  - pause=0: go to RUN, q unchanged at this edge. This is a one-cycle resume bubble.
  - Otherwise remain in PAUSE.
- Timing, one-shot with start seen at edge N and no pause: q=k after edge N+k (k=0..limit_r). done is high for the single cycle after edge N+limit_r+1. state returns to IDLE at that same edge.
- Auto-reload period: limit_r+1 cycles per wrap. done pulses once per period; busy stays 1.
- limit=0: the first RUN edge is terminal. One-shot gives done one cycle after edge N+1. Auto-reload gives q constantly 0 with done high every cycle.
- limit = all-ones: q reaches 2^WIDTH-1 without arithmetic overflow. The increment is never applied at q==limit_r.
- start while busy is ignored; the current sequence continues. Changes to limit or auto_reload while busy have no effect until the next start.
- Reset mid-sequence: all outputs clear immediately with no done pulse. The block restarts only on a new start after release.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, then drop rst_n asynchronously mid-cycle during RUN with q=7 -> q=0, busy=0, done=0, state=0 before the next rising edge.
2. One-shot, limit=5, auto_reload=0, start pulse at edge N -> q=0,1,2,3,4,5 after edges N..N+5. done=1 for exactly one cycle after edge N+6. busy falls at N+6. q holds 5.
3. Auto-reload, limit=3, run 20 cycles -> q repeats 0,1,2,3. done pulses every 4th cycle (5 pulses). busy stays 1. stop then returns to IDLE with q held.
4. Pause, limit=15: assert pause when q=4 for 3 cycles -> state=2 and q=4 throughout. After release, q=4 for one more edge, then 5,6,... Terminal timing is shifted by 4 cycles.
5. Collisions: stop in the terminal cycle (q==limit_r) -> IDLE with no done. start and stop together in IDLE -> stays IDLE. start during RUN -> ignored, q continues.
6. Bounds:
   - limit=0 one-shot -> done one cycle after edge N+1.
   - limit=0 auto-reload -> done high continuously, q=0.
   - limit=15 (WIDTH=4) -> q reaches 15, then done; no wrap to 0 in one-shot mode.
